// File: rtl/lapic_irq_receiver.sv
// Local APIC interrupt receiver: accepts IOAPIC messages, tracks IRR/ISR,
// offers the highest-priority vector to the CPU and returns EOIs.
module lapic_irq_receiver #(
    parameter logic [7:0] SPURIOUS_VEC = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_enable,
    input  logic [7:0] cfg_apic_id,
    input  logic [7:0] cfg_tpr,
    input  logic       irq_in_valid,
    input  logic [7:0] irq_in_vector,
    input  logic [7:0] irq_in_dest,
    input  logic [2:0] irq_in_deliv_mode,
    output logic       irq_in_ready,
    output logic       cpu_intr,
    output logic [7:0] cpu_intr_vector,
    input  logic       cpu_inta,
    input  logic       cpu_eoi,
    output logic       nmi_out,
    output logic       eoi_out,
    output logic [7:0] eoi_out_vector,
    output logic [7:0] status_ppr,
    output logic       status_drop,
    output logic       status_spurious,
    output logic [7:0] status_spurious_vector
);

    localparam logic [2:0] MODE_FIXED  = 3'b000;
    localparam logic [2:0] MODE_LOWPRI = 3'b001;
    localparam logic [2:0] MODE_NMI    = 3'b100;
    localparam logic [7:0] DEST_BCAST  = 8'hFF;
    localparam logic [7:0] MIN_VECTOR  = 8'h10;

    logic [255:0] irr_q, irr_d;
    logic [255:0] isr_q, isr_d;
    logic         ready_q, ready_d;
    logic         intr_q, intr_d;
    logic [7:0]   intr_vec_q, intr_vec_d;
    logic         nmi_q, nmi_d;
    logic         eoi_q, eoi_d;
    logic [7:0]   eoi_vec_q, eoi_vec_d;
    logic [7:0]   ppr_q, ppr_d;
    logic         drop_q, drop_d;
    logic         spur_q, spur_d;

    logic [7:0]   irrv;
    logic [7:0]   isrv;
    logic         irr_any;
    logic         isr_any;

    logic         accept;
    logic         dest_hit;
    logic         msg_set;
    logic         msg_nmi;
    logic         msg_drop;

    logic         ack;
    logic         spur;
    logic         eoi_fire;

    assign irr_any = |irr_q;
    assign isr_any = |isr_q;

    // Highest pending vector; bits are scanned upward so the top one wins.
    always_comb begin
        irrv = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (irr_q[i]) begin
                irrv = 8'(i);
            end
        end
    end

    // Highest in-service vector, zero when nothing is in service.
    always_comb begin
        isrv = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (isr_q[i]) begin
                isrv = 8'(i);
            end
        end
    end

    assign accept   = irq_in_valid && ready_q;
    assign dest_hit = (irq_in_dest == cfg_apic_id) ||
                      (irq_in_dest == DEST_BCAST);

    // Classify an accepted message: latch, NMI pulse or drop.
    always_comb begin
        msg_set  = 1'b0;
        msg_nmi  = 1'b0;
        msg_drop = 1'b0;
        if (accept && dest_hit) begin
            if (!cfg_enable) begin
                msg_drop = 1'b1;
            end else begin
                unique case (irq_in_deliv_mode)
                    MODE_FIXED, MODE_LOWPRI: begin
                        if (irq_in_vector >= MIN_VECTOR) begin
                            msg_set = 1'b1;
                        end else begin
                            msg_drop = 1'b1;
                        end
                    end
                    MODE_NMI: begin
                        msg_nmi = 1'b1;
                    end
                    default: begin
                        msg_drop = 1'b1;
                    end
                endcase
            end
        end
    end

    assign ack      = cpu_inta && intr_q;
    assign spur     = cpu_inta && !intr_q;
    assign eoi_fire = cpu_eoi && isr_any;

    // Request/service register updates; a new arrival beats an ack clear,
    // and an ack sets its ISR bit after the EOI has retired the old top.
    always_comb begin
        irr_d = irr_q;
        isr_d = isr_q;
        if (ack) begin
            irr_d[intr_vec_q] = 1'b0;
        end
        if (msg_set) begin
            irr_d[irq_in_vector] = 1'b1;
        end
        if (eoi_fire) begin
            isr_d[isrv] = 1'b0;
        end
        if (ack) begin
            isr_d[intr_vec_q] = 1'b1;
        end
    end

    // Priority evaluation and registered CPU-facing outputs.
    always_comb begin
        ready_d    = 1'b1;
        ppr_d      = cfg_tpr;
        intr_d     = 1'b0;
        intr_vec_d = irrv;
        nmi_d      = msg_nmi;
        drop_d     = msg_drop;
        spur_d     = spur;
        eoi_d      = eoi_fire;
        eoi_vec_d  = 8'h00;
        if (cfg_tpr[7:4] < isrv[7:4]) begin
            ppr_d = {isrv[7:4], 4'h0};
        end
        if (cfg_enable && irr_any && !ack) begin
            intr_d = irrv[7:4] > ppr_d[7:4];
        end
        if (eoi_fire) begin
            eoi_vec_d = isrv;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            irr_q      <= '0;
            isr_q      <= '0;
            ready_q    <= 1'b0;
            intr_q     <= 1'b0;
            intr_vec_q <= 8'h00;
            nmi_q      <= 1'b0;
            eoi_q      <= 1'b0;
            eoi_vec_q  <= 8'h00;
            ppr_q      <= 8'h00;
            drop_q     <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            ready_q    <= ready_d;
            intr_q     <= intr_d;
            intr_vec_q <= intr_vec_d;
            nmi_q      <= nmi_d;
            eoi_q      <= eoi_d;
            eoi_vec_q  <= eoi_vec_d;
            ppr_q      <= ppr_d;
            drop_q     <= drop_d;
            spur_q     <= spur_d;
        end
    end

    assign irq_in_ready           = ready_q;
    assign cpu_intr               = intr_q;
    assign cpu_intr_vector        = intr_vec_q;
    assign nmi_out                = nmi_q;
    assign eoi_out                = eoi_q;
    assign eoi_out_vector         = eoi_vec_q;
    assign status_ppr             = ppr_q;
    assign status_drop            = drop_q;
    assign status_spurious        = spur_q;
    assign status_spurious_vector = spur_q ? SPURIOUS_VEC : 8'h00;

endmodule

// File: tb/tb_lapic_irq_receiver.sv
// Testbench for lapic_irq_receiver: directed scenarios plus a randomized
// run against a set-based reference model.
module tb_lapic_irq_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_enable = 1'b0;
    logic [7:0] cfg_apic_id = 8'h03;
    logic [7:0] cfg_tpr = 8'h00;
    logic       irq_in_valid = 1'b0;
    logic [7:0] irq_in_vector = 8'h00;
    logic [7:0] irq_in_dest = 8'h00;
    logic [2:0] irq_in_deliv_mode = 3'b000;
    logic       irq_in_ready;
    logic       cpu_intr;
    logic [7:0] cpu_intr_vector;
    logic       cpu_inta = 1'b0;
    logic       cpu_eoi = 1'b0;
    logic       nmi_out;
    logic       eoi_out;
    logic [7:0] eoi_out_vector;
    logic [7:0] status_ppr;
    logic       status_drop;
    logic       status_spurious;
    logic [7:0] status_spurious_vector;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lapic_irq_receiver #(.SPURIOUS_VEC(8'hFF)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_enable             (cfg_enable),
        .cfg_apic_id            (cfg_apic_id),
        .cfg_tpr                (cfg_tpr),
        .irq_in_valid           (irq_in_valid),
        .irq_in_vector          (irq_in_vector),
        .irq_in_dest            (irq_in_dest),
        .irq_in_deliv_mode      (irq_in_deliv_mode),
        .irq_in_ready           (irq_in_ready),
        .cpu_intr               (cpu_intr),
        .cpu_intr_vector        (cpu_intr_vector),
        .cpu_inta               (cpu_inta),
        .cpu_eoi                (cpu_eoi),
        .nmi_out                (nmi_out),
        .eoi_out                (eoi_out),
        .eoi_out_vector         (eoi_out_vector),
        .status_ppr             (status_ppr),
        .status_drop            (status_drop),
        .status_spurious        (status_spurious),
        .status_spurious_vector (status_spurious_vector)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        irq_in_valid = 1'b0;
        cpu_inta     = 1'b0;
        cpu_eoi      = 1'b0;
        cfg_enable   = 1'b1;
        cfg_apic_id  = 8'h03;
        cfg_tpr      = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] v,
                        input logic [2:0] m);
        irq_in_valid      = 1'b1;
        irq_in_dest       = d;
        irq_in_vector     = v;
        irq_in_deliv_mode = m;
        tick();
        irq_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({irq_in_ready, cpu_intr, nmi_out, eoi_out, status_drop,
             status_spurious} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {irq_in_ready, cpu_intr, nmi_out, eoi_out,
                      status_drop, status_spurious});
        end
        n_tests++;
        if ({cpu_intr_vector, eoi_out_vector, status_ppr,
             status_spurious_vector} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vectors: got %h want 0",
                     {cpu_intr_vector, eoi_out_vector, status_ppr,
                      status_spurious_vector});
        end
        rst = 1'b0;
        cfg_enable = 1'b1;
        tick();
        n_tests++;
        if (irq_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", irq_in_ready);
        end
    endtask

    task automatic test_basic();
        send(8'h03, 8'h41, 3'b000);
        n_tests++;
        if (cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got %b want 0", cpu_intr);
        end
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h41) begin
            n_fail++;
            $display("FAIL basic_intr: got %b/%h want 1/41",
                     cpu_intr, cpu_intr_vector);
        end
    endtask

    task automatic test_ack();
        send(8'h03, 8'h62, 3'b000);
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h62) begin
            n_fail++;
            $display("FAIL ack_higher: got %b/%h want 1/62",
                     cpu_intr, cpu_intr_vector);
        end
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        n_tests++;
        if (cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_forced_low: got %b want 0", cpu_intr);
        end
        tick();
        n_tests++;
        if (status_ppr !== 8'h60 || cpu_intr !== 1'b0 ||
            cpu_intr_vector !== 8'h41) begin
            n_fail++;
            $display("FAIL ack_ppr_block: got %h/%b/%h want 60/0/41",
                     status_ppr, cpu_intr, cpu_intr_vector);
        end
    endtask

    task automatic test_nested();
        send(8'h03, 8'h85, 3'b000);
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h85) begin
            n_fail++;
            $display("FAIL nested_offer: got %b/%h want 1/85",
                     cpu_intr, cpu_intr_vector);
        end
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        cpu_eoi = 1'b1;
        tick();
        n_tests++;
        if (eoi_out !== 1'b1 || eoi_out_vector !== 8'h85) begin
            n_fail++;
            $display("FAIL nested_eoi1: got %b/%h want 1/85",
                     eoi_out, eoi_out_vector);
        end
        tick();
        n_tests++;
        if (eoi_out !== 1'b1 || eoi_out_vector !== 8'h62) begin
            n_fail++;
            $display("FAIL nested_eoi2: got %b/%h want 1/62",
                     eoi_out, eoi_out_vector);
        end
        tick();
        cpu_eoi = 1'b0;
        n_tests++;
        if (eoi_out !== 1'b0) begin
            n_fail++;
            $display("FAIL nested_eoi3: got %b want 0", eoi_out);
        end
    endtask

    task automatic test_filter();
        do_reset();
        send(8'h07, 8'h50, 3'b000);
        n_tests++;
        if (status_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_mismatch_drop: got %b want 0", status_drop);
        end
        tick();
        n_tests++;
        if (cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_mismatch_intr: got %b want 0", cpu_intr);
        end
        send(8'hFF, 8'h05, 3'b000);
        n_tests++;
        if (status_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL filter_low_vec: got %b want 1", status_drop);
        end
        send(8'h03, 8'h50, 3'b101);
        n_tests++;
        if (status_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL filter_init: got %b want 1", status_drop);
        end
        send(8'h03, 8'h02, 3'b100);
        n_tests++;
        if (nmi_out !== 1'b1 || status_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_nmi: got %b/%b want 1/0",
                     nmi_out, status_drop);
        end
        tick();
        tick();
        n_tests++;
        if (nmi_out !== 1'b0 || cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_nmi_irr: got %b/%b want 0/0",
                     nmi_out, cpu_intr);
        end
        send(8'hFF, 8'h90, 3'b001);
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h90) begin
            n_fail++;
            $display("FAIL filter_bcast: got %b/%h want 1/90",
                     cpu_intr, cpu_intr_vector);
        end
        cfg_enable = 1'b0;
        send(8'h03, 8'h91, 3'b000);
        n_tests++;
        if (status_drop !== 1'b1 || cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_disabled: got %b/%b want 1/0",
                     status_drop, cpu_intr);
        end
        cfg_enable = 1'b1;
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h90) begin
            n_fail++;
            $display("FAIL filter_reenable: got %b/%h want 1/90",
                     cpu_intr, cpu_intr_vector);
        end
    endtask

    task automatic test_tpr();
        do_reset();
        cfg_tpr = 8'h50;
        send(8'h03, 8'h52, 3'b000);
        tick();
        n_tests++;
        if (cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL tpr_block: got %b want 0", cpu_intr);
        end
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        n_tests++;
        if (status_spurious !== 1'b1 || status_spurious_vector !== 8'hFF) begin
            n_fail++;
            $display("FAIL spurious: got %b/%h want 1/ff",
                     status_spurious, status_spurious_vector);
        end
        cfg_tpr = 8'h40;
        tick();
        n_tests++;
        if (status_spurious !== 1'b0 || status_spurious_vector !== 8'h00) begin
            n_fail++;
            $display("FAIL spurious_end: got %b/%h want 0/00",
                     status_spurious, status_spurious_vector);
        end
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h52 ||
            status_ppr !== 8'h40) begin
            n_fail++;
            $display("FAIL tpr_lower: got %b/%h/%h want 1/52/40",
                     cpu_intr, cpu_intr_vector, status_ppr);
        end
    endtask

    task automatic test_same_edge();
        do_reset();
        send(8'h03, 8'h30, 3'b000);
        tick();
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        send(8'h03, 8'h70, 3'b000);
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h70) begin
            n_fail++;
            $display("FAIL same_offer: got %b/%h want 1/70",
                     cpu_intr, cpu_intr_vector);
        end
        cpu_inta = 1'b1;
        cpu_eoi  = 1'b1;
        tick();
        cpu_inta = 1'b0;
        cpu_eoi  = 1'b0;
        n_tests++;
        if (eoi_out !== 1'b1 || eoi_out_vector !== 8'h30 ||
            cpu_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL same_eoi: got %b/%h/%b want 1/30/0",
                     eoi_out, eoi_out_vector, cpu_intr);
        end
        tick();
        n_tests++;
        if (status_ppr !== 8'h70) begin
            n_fail++;
            $display("FAIL same_ppr: got %h want 70", status_ppr);
        end
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
        n_tests++;
        if (eoi_out !== 1'b1 || eoi_out_vector !== 8'h70) begin
            n_fail++;
            $display("FAIL same_isr70: got %b/%h want 1/70",
                     eoi_out, eoi_out_vector);
        end
    endtask

    task automatic test_accept_ack();
        do_reset();
        send(8'h03, 8'h44, 3'b000);
        tick();
        irq_in_valid      = 1'b1;
        irq_in_dest       = 8'h03;
        irq_in_vector     = 8'h44;
        irq_in_deliv_mode = 3'b000;
        cpu_inta          = 1'b1;
        tick();
        irq_in_valid = 1'b0;
        cpu_inta     = 1'b0;
        tick();
        n_tests++;
        if (cpu_intr !== 1'b0 || cpu_intr_vector !== 8'h44 ||
            status_ppr !== 8'h40) begin
            n_fail++;
            $display("FAIL acc_ack_irr: got %b/%h/%h want 0/44/40",
                     cpu_intr, cpu_intr_vector, status_ppr);
        end
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
        n_tests++;
        if (eoi_out !== 1'b1 || eoi_out_vector !== 8'h44) begin
            n_fail++;
            $display("FAIL acc_ack_eoi: got %b/%h want 1/44",
                     eoi_out, eoi_out_vector);
        end
        tick();
        n_tests++;
        if (cpu_intr !== 1'b1 || cpu_intr_vector !== 8'h44) begin
            n_fail++;
            $display("FAIL acc_ack_reoffer: got %b/%h want 1/44",
                     cpu_intr, cpu_intr_vector);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h03, 8'h40, 3'b000);
        tick();
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        send(8'h03, 8'h60, 3'b000);
        cpu_eoi = 1'b1;
        rst     = 1'b1;
        tick();
        n_tests++;
        if ({irq_in_ready, cpu_intr, eoi_out, nmi_out, status_drop} !== 5'b0 ||
            cpu_intr_vector !== 8'h00 || status_ppr !== 8'h00 ||
            eoi_out_vector !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got %b %h %h %h want 00000 00 00 00",
                     {irq_in_ready, cpu_intr, eoi_out, nmi_out, status_drop},
                     cpu_intr_vector, status_ppr, eoi_out_vector);
        end
        rst = 1'b0;
        tick();
        tick();
        tick();
        cpu_eoi = 1'b0;
        n_tests++;
        if (cpu_intr !== 1'b0 || eoi_out !== 1'b0 || status_ppr !== 8'h00 ||
            irq_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b/%b/%h/%b want 0/0/00/1",
                     cpu_intr, eoi_out, status_ppr, irq_in_ready);
        end
    endtask

    function automatic logic [7:0] top_of(input logic [255:0] s);
        for (int i = 255; i >= 0; i--) begin
            if (s[i]) return 8'(i);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] prio_of(input logic [7:0] tpr,
                                           input logic [255:0] ins);
        logic [7:0] t;
        t = top_of(ins);
        if (tpr[7:4] >= t[7:4]) return tpr;
        return {t[7:4], 4'h0};
    endfunction

    task automatic test_random();
        logic [255:0] m_irr;
        logic [255:0] m_isr;
        logic         m_intr;
        logic [7:0]   m_vec;
        logic         e_intr, e_nmi, e_drop, e_spur, e_eoi;
        logic [7:0]   e_vec, e_ppr, e_eoiv, ppr, hv, ev;
        logic         hit, ack;
        int           r;
        do_reset();
        m_irr  = '0;
        m_isr  = '0;
        m_intr = 1'b0;
        m_vec  = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 15) == 0) cfg_tpr = 8'($urandom_range(0, 255));
            irq_in_valid = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            irq_in_dest = (r == 0) ? 8'h07 : (r == 1) ? 8'hFF : 8'h03;
            irq_in_vector = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            irq_in_deliv_mode = (r < 6) ? 3'(r & 1) : 3'($urandom_range(0, 7));
            cpu_inta = ($urandom_range(0, 3) == 0);
            cpu_eoi  = ($urandom_range(0, 3) == 0);

            hit    = irq_in_valid && (irq_in_dest == 8'h03 || irq_in_dest == 8'hFF);
            e_nmi  = 1'b0;
            e_drop = 1'b0;
            if (hit && !cfg_enable) begin
                e_drop = 1'b1;
            end else if (hit) begin
                if (irq_in_deliv_mode == 3'b100) e_nmi = 1'b1;
                else if (irq_in_deliv_mode > 3'b001 || irq_in_vector < 8'h10)
                    e_drop = 1'b1;
            end
            ack    = cpu_inta && m_intr;
            e_spur = cpu_inta && !m_intr;
            e_eoi  = cpu_eoi && (m_isr != 0);
            ev     = top_of(m_isr);
            e_eoiv = ev;
            ppr    = prio_of(cfg_tpr, m_isr);
            hv     = top_of(m_irr);
            e_ppr  = ppr;
            e_vec  = hv;
            e_intr = !ack && cfg_enable && (m_irr != 0) && (hv[7:4] > ppr[7:4]);

            tick();

            n_tests++;
            if (cpu_intr !== e_intr || cpu_intr_vector !== e_vec ||
                status_ppr !== e_ppr) begin
                n_fail++;
                $display("FAIL rand_prio c=%0d: got %b/%h/%h want %b/%h/%h", c,
                         cpu_intr, cpu_intr_vector, status_ppr,
                         e_intr, e_vec, e_ppr);
            end
            n_tests++;
            if (nmi_out !== e_nmi || status_drop !== e_drop ||
                status_spurious !== e_spur ||
                status_spurious_vector !== (e_spur ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL rand_pulse c=%0d: got %b%b%b/%h want %b%b%b", c,
                         nmi_out, status_drop, status_spurious,
                         status_spurious_vector, e_nmi, e_drop, e_spur);
            end
            n_tests++;
            if (eoi_out !== e_eoi || (e_eoi && eoi_out_vector !== e_eoiv)) begin
                n_fail++;
                $display("FAIL rand_eoi c=%0d: got %b/%h want %b/%h", c,
                         eoi_out, eoi_out_vector, e_eoi, e_eoiv);
            end

            if (e_eoi) m_isr[ev] = 1'b0;
            if (ack) begin
                m_irr[m_vec] = 1'b0;
                m_isr[m_vec] = 1'b1;
            end
            if (hit && cfg_enable && irq_in_deliv_mode <= 3'b001 &&
                irq_in_vector >= 8'h10)
                m_irr[irq_in_vector] = 1'b1;
            m_intr = e_intr;
            m_vec  = e_vec;
        end
        irq_in_valid = 1'b0;
        cpu_inta     = 1'b0;
        cpu_eoi      = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack();
        test_nested();
        test_filter();
        test_tpr();
        test_same_edge();
        test_accept_ack();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lapic_irq_receiver.md
Name: lapic_irq_receiver

Overview:
- Local-APIC-side endpoint of the IOAPIC interrupt message interface.
- Accepts valid/ready interrupt messages with vector, destination and delivery mode, and filters them by APIC ID.
- Latches fixed interrupts into a 256-bit IRR and presents the highest-priority vector to the CPU.
- On CPU acknowledge, moves that vector from IRR to ISR. On CPU EOI, retires the highest ISR vector and returns an EOI strobe plus vector to the IOAPIC. Level-triggered sources rely on that strobe to clear Remote IRR.

Parameters:
SPURIOUS_VEC, 8'hFF, vector reported on status_spurious_vector for acknowledges with nothing pending

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  reset, synchronous, active-high
cfg_enable  input  1  1=APIC enabled
cfg_apic_id  input  8  local APIC ID
cfg_tpr  input  8  task priority register; class = [7:4]
irq_in_valid  input  1  message valid
irq_in_vector  input  8  message vector
irq_in_dest  input  8  destination APIC ID; 8'hFF = broadcast
irq_in_deliv_mode  input  3  000 Fixed, 001 LowestPri, 010 SMI, 100 NMI, 101 INIT, 111 ExtINT
irq_in_ready  output  1  message accepted when valid&ready
cpu_intr  output  1  interrupt request to CPU
cpu_intr_vector  output  8  vector offered with cpu_intr
cpu_inta  input  1  CPU acknowledge pulse
cpu_eoi  input  1  CPU end-of-interrupt pulse
nmi_out  output  1  one-cycle NMI pulse
eoi_out  output  1  one-cycle EOI strobe toward IOAPIC
eoi_out_vector  output  8  vector being EOI'd
status_ppr  output  8  processor priority
status_drop  output  1  one-cycle pulse: accepted message discarded
status_spurious  output  1  one-cycle pulse: cpu_inta with cpu_intr=0
status_spurious_vector  output  8  SPURIOUS_VEC while status_spurious=1, else 0

Behaviour:
- Reset (rst=1 at an edge) clears all state.
  - IRR=0, ISR=0.
  - irq_in_ready, cpu_intr, nmi_out, eoi_out and all status pulses = 0.
  - cpu_intr_vector=0, eoi_out_vector=0, status_ppr=0.
  - irq_in_ready rises on the first edge after rst falls; afterwards it stays 1 (one message per cycle).
  - Reset mid-delivery discards everything; no EOI is emitted.
- Accept (valid&ready at edge N). A message matches when dest==cfg_apic_id or dest==8'hFF. Handling by case:
  - No match: silently ignored (no drop pulse).
  - cfg_enable=0: dropped, status_drop at N+1.
  - Fixed or LowestPri with vector>=8'h10: IRR[vector] set at N+1. If the bit is already set, the message coalesces (no error).
  - Fixed or LowestPri with vector<8'h10: dropped, status_drop.
  - NMI: nmi_out pulses at N+1; IRR is unchanged.
  - SMI, INIT, ExtINT or reserved modes: dropped, status_drop.
- Priority.
  - ISRV = highest set ISR bit, or 0 if ISR is empty.
  - PPR = cfg_tpr if cfg_tpr[7:4] >= ISRV[7:4], else {ISRV[7:4],4'h0}. PPR is registered and output as status_ppr.
  - IRRV = highest set IRR bit.
  - cpu_intr (registered) = cfg_enable && IRR!=0 && IRRV[7:4] > PPR[7:4]. cpu_intr_vector is registered as IRRV.
  - Latency: message accept at edge N, IRR at N+1, cpu_intr at N+2.
  - cpu_intr_vector may change while cpu_intr=1 when a higher vector arrives. The CPU takes whatever is presented at the edge where cpu_inta is sampled.
- Acknowledge (cpu_inta=1 and cpu_intr=1 at edge M):
  - IRR[cpu_intr_vector] is cleared and ISR[cpu_intr_vector] is set at M.
  - cpu_intr is forced 0 for the cycle after M and is re-evaluated from new state at M+1.
  - cpu_inta with cpu_intr=0: no state change; status_spurious pulses.
- EOI (cpu_eoi at edge K):
  - ISR[ISRV] is cleared.
  - eoi_out=1 and eoi_out_vector=ISRV for the one cycle following K.
  - cpu_eoi with ISR empty: no eoi_out, no state change.
- Simultaneous events in the same edge:
  - EOI evaluates against the pre-edge ISR; INTA sets its bit after that. The newly acked vector is never retired by the same EOI.
  - Accept and INTA on the same vector: IRR ends set, because the new arrival wins. ISR is still set.
  - Accept of an NMI never blocks or delays fixed-interrupt processing.
- Disable: cfg_enable=0 forces cpu_intr=0. IRR and ISR are retained, and EOI still functions.

Test Plan:
- Reset then Fixed msg dest=cfg_apic_id=8'h03, vector 8'h41, TPR=0 -> irq_in_ready=1 one cycle after reset. cpu_intr=1 and cpu_intr_vector=8'h41 two edges after accept.
- IRR holds 8'h41; send 8'h62 -> cpu_intr_vector becomes 8'h62. cpu_inta -> ISR[62]=1, PPR=8'h60, cpu_intr low. 8'h41 stays pending and blocked, because class 4 <= class 6.
- Nested: ISR[0x62] and ISR[0x85] set; cpu_eoi -> eoi_out pulse with vector 8'h85. Second cpu_eoi -> 8'h62. Third cpu_eoi -> no eoi_out.
- Filtering: dest=8'h07 (mismatch) -> no change, no drop. dest=8'hFF vector 8'h05 -> status_drop. Mode INIT -> status_drop. Mode NMI -> nmi_out pulse, IRR unchanged.
- TPR=8'h50 with IRR vector 8'h52 -> cpu_intr=0. TPR=8'h40 -> cpu_intr=1 next edge. cpu_inta while cpu_intr=0 -> status_spurious with vector 8'hFF.
- Same-edge cpu_eoi and cpu_inta with ISR={0x30}, offered 8'h70 -> eoi_out_vector=8'h30 and ISR={0x70}. Assert rst mid-sequence -> all outputs 0, no eoi_out.
